liushuideng_monitor: RTL and testbench

Receive-side checker for the 8-bit running-light bus: samples `led[7:0]`, decodes the lit position, and verifies the rotation sequence and per-step dwell time. It locks onto a clean sequence and flags any skipped, reversed, multi-hot or irregular step. It sits on the board-level LED bus beside the running-light driver, for self-test and for bench checking of that driver.

---
 rtl/liushuideng_pkg.sv | 28 ++
 rtl/liushuideng_onehot_dec.sv | 23 ++
 rtl/liushuideng_monitor.sv | 168 ++++++++++++++++
 tb/tb_liushuideng_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/liushuideng_pkg.sv
// Shared types and helpers for the running-light bus monitor.
package liushuideng_pkg;

  localparam int unsigned LED_WIDTH_DEF = 8;
  // Helpers work on a fixed wide vector; callers zero-extend their bus into it.
  localparam int unsigned MAX_W         = 64;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } state_e;

  // Rotate the low w bits of v up by one; bit w-1 wraps to bit 0. Upper bits stay zero.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
    r    = ((v << 1) | (v >> (w - 1))) & mask;
    return r;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/liushuideng_onehot_dec.sv
// One-hot to index decoder; valid_o is low for zero or multi-hot inputs.
module liushuideng_onehot_dec
  import liushuideng_pkg::*;
#(
  parameter int unsigned WIDTH = LED_WIDTH_DEF
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  // OR together the indices of all set bits; exact when the input is one-hot.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_o = idx_o | IDX_W'(i);
    end
    valid_o = is_onehot(MAX_W'(vec_i));
  end

endmodule

// File: rtl/liushuideng_monitor.sv
// Receive-side checker for the running-light LED bus: decodes the lit position,
// measures per-step dwell, locks onto a clean upward rotation and flags faults.
module liushuideng_monitor
  import liushuideng_pkg::*;
#(
  parameter int unsigned WIDTH      = LED_WIDTH_DEF,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned LOCK_STEPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         led,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     onehot,
  output logic                     step,
  output logic [CNT_W-1:0]         dwell,
  output logic                     locked,
  output logic                     err
);

  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned GOOD_W = $clog2(LOCK_STEPS + 1);

  logic [WIDTH-1:0]  led_q;
  logic [WIDTH-1:0]  led_p_q;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  state_e            state_q,    state_d;
  logic [GOOD_W-1:0] good_q,     good_d;
  logic [CNT_W-1:0]  ref_q,      ref_d;
  logic              step_q;
  logic [CNT_W-1:0]  dwell_q,    dwell_d;
  logic              locked_q;
  logic              err_q,      err_d;
  logic [IDX_W-1:0]  pos_hold_q, pos_hold_d;

  logic [IDX_W-1:0]  dec_idx_c;
  logic              dec_valid_c;
  logic              change_c;
  logic              vstep_c;
  logic              bad_change_c;
  logic              cnt_sat_c;
  logic              dwell_ok_c;
  logic              fault_c;

  liushuideng_onehot_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .vec_i   (led_q),
    .idx_o   (dec_idx_c),
    .valid_o (dec_valid_c)
  );

  // Step classification between the two most recent samples.
  always_comb begin
    change_c     = (led_q != led_p_q);
    vstep_c      = is_onehot(MAX_W'(led_p_q)) && dec_valid_c &&
                   (MAX_W'(led_q) == rotl1(MAX_W'(led_p_q), WIDTH));
    bad_change_c = change_c && !vstep_c;
    cnt_sat_c    = (cnt_q == {CNT_W{1'b1}});
    dwell_ok_c   = (cnt_q == ref_q);
  end

  // Dwell counter: restarts at 1 on any change, otherwise counts up and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (change_c) begin
      cnt_d = CNT_W'(1);
    end else if (!cnt_sat_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sequence tracker: SEARCH for a valid step, ACQ to confirm a stable dwell, LOCK to police it.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    ref_d   = ref_q;
    fault_c = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vstep_c) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (bad_change_c) begin
          state_d = SEARCH;
          good_d  = '0;
        end else if (vstep_c) begin
          if (good_q == '0) begin
            ref_d  = cnt_q;
            good_d = GOOD_W'(1);
          end else if (!dwell_ok_c) begin
            state_d = SEARCH;
            good_d  = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
          if ((state_d == ACQ) && (good_d == GOOD_W'(LOCK_STEPS))) begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (bad_change_c || !dec_valid_c || (vstep_c && !dwell_ok_c) || cnt_sat_c) begin
          fault_c = 1'b1;
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  // Next values for the reported dwell, sticky error and held position.
  always_comb begin
    err_d = err_q;
    if (fault_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    dwell_d    = vstep_c ? cnt_q : dwell_q;
    pos_hold_d = dec_valid_c ? dec_idx_c : pos_hold_q;
  end

  // All state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      led_p_q    <= '0;
      cnt_q      <= CNT_W'(1);
      state_q    <= SEARCH;
      good_q     <= '0;
      ref_q      <= '0;
      step_q     <= 1'b0;
      dwell_q    <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      pos_hold_q <= '0;
    end else begin
      led_q      <= led;
      led_p_q    <= led_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      good_q     <= good_d;
      ref_q      <= ref_d;
      step_q     <= vstep_c;
      dwell_q    <= dwell_d;
      locked_q   <= (state_d == LOCK);
      err_q      <= err_d;
      pos_hold_q <= pos_hold_d;
    end
  end

  assign onehot = dec_valid_c;
  assign pos    = dec_valid_c ? dec_idx_c : pos_hold_q;
  assign step   = step_q;
  assign dwell  = dwell_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule

// File: tb/tb_liushuideng_monitor.sv
// Scoreboard bench for liushuideng_monitor: a run-length model of the LED stream
// predicts every cycle's outputs; a monitor pops and compares them after each edge.
`timescale 1ns/1ps
module tb_liushuideng_monitor;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int LS   = 4;
  localparam int CMAX = 15;
  localparam int S_SEARCH = 0;
  localparam int S_ACQ    = 1;
  localparam int S_LOCK   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  led = '0;
  logic          err_clr = 1'b0;
  logic [2:0]    pos;
  logic          onehot;
  logic          step;
  logic [CW-1:0] dwell;
  logic          locked;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit oh;
    int pos;
    bit step;
    int dwell;
    bit locked;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // reference model state: run lengths over the sampled LED stream
  int          m_state, m_good, m_ref, m_run, m_dwell, m_pos;
  bit          m_step, m_locked, m_err;
  logic [7:0]  m_prev, m_pend;
  int          cur;

  liushuideng_monitor #(
    .WIDTH      (W),
    .CNT_W      (CW),
    .LOCK_STEPS (LS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .led     (led),
    .err_clr (err_clr),
    .pos     (pos),
    .onehot  (onehot),
    .step    (step),
    .dwell   (dwell),
    .locked  (locked),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit f_oh(input logic [7:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int f_idx(input logic [7:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] oh_of(input int i);
    logic [7:0] v;
    v = 8'd1 << i;
    return v;
  endfunction

  function automatic void model_reset();
    m_state = S_SEARCH; m_good = 0; m_ref = 0; m_run = 1; m_dwell = 0; m_pos = 0;
    m_step = 0; m_locked = 0; m_err = 0; m_prev = 8'h00; m_pend = 8'h00;
  endfunction

  // Judge sample s against the one before it; clr is err_clr seen on the same edge.
  function automatic void model_eval(input logic [7:0] s, input bit clr);
    bit chg, vs, sat, fault;
    chg   = (s != m_prev);
    vs    = f_oh(m_prev) && f_oh(s) && (f_idx(s) == (f_idx(m_prev) + 1) % W);
    sat   = (m_run == CMAX);
    fault = 0;
    m_step = vs;
    if (vs) m_dwell = m_run;
    if (m_state == S_SEARCH) begin
      if (vs) begin m_state = S_ACQ; m_good = 0; end
    end else if (m_state == S_ACQ) begin
      if (chg && !vs) begin
        m_state = S_SEARCH; m_good = 0;
      end else if (vs) begin
        if (m_good == 0) begin m_ref = m_run; m_good = 1; end
        else if (m_run != m_ref) begin m_state = S_SEARCH; m_good = 0; end
        else m_good++;
        if (m_state == S_ACQ && m_good == LS) m_state = S_LOCK;
      end
    end else begin
      if ((chg && !vs) || !f_oh(s) || (vs && m_run != m_ref) || sat) begin
        fault = 1; m_state = S_SEARCH; m_good = 0;
      end
    end
    m_locked = (m_state == S_LOCK);
    if (fault) m_err = 1;
    else if (clr) m_err = 0;
    m_run  = chg ? 1 : ((m_run < CMAX) ? m_run + 1 : CMAX);
    m_prev = s;
  endfunction

  // Drive one sample and queue the outputs expected right after the next edge.
  task automatic apply(input logic [7:0] v, input bit clr);
    exp_t e;
    led     = v;
    err_clr = clr;
    model_eval(m_pend, clr);
    if (f_oh(v)) m_pos = f_idx(v);
    e.oh = f_oh(v); e.pos = m_pos; e.step = m_step; e.dwell = m_dwell;
    e.locked = m_locked; e.err = m_err;
    exp_q.push_back(e);
    m_pend = v;
  endtask

  task automatic drive1(input logic [7:0] v, input bit clr);
    @(negedge clk);
    apply(v, clr);
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    repeat (n) drive1(v, 1'b0);
  endtask

  task automatic run_clean(input int n, input int d);
    repeat (n) begin
      cur = (cur + 1) % W;
      hold(oh_of(cur), d);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic reset_dut(input logic [7:0] v0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_pos", 32'(pos), 0);
    chk("rst_onehot", 32'(onehot), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_dwell", 32'(dwell), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    led = v0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold_onehot", 32'(onehot), 0);
    model_reset();
    rst = 1'b0;
    apply(v0, 1'b0);
  endtask

  // Monitor: one expected record per edge outside reset.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("onehot", 32'(onehot), 32'(mon_e.oh));
      chk("pos",    32'(pos),    32'(mon_e.pos));
      chk("step",   32'(step),   32'(mon_e.step));
      chk("dwell",  32'(dwell),  32'(mon_e.dwell));
      chk("locked", 32'(locked), 32'(mon_e.locked));
      chk("err",    32'(err),    32'(mon_e.err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int r, d, n;
    logic [7:0] rv;
    model_reset();
    reset_dut(8'h01);
    cur = 0;
    hold(8'h01, 2);
    // clean lock with dwell 3, including the 80->01 wrap
    run_clean(12, 3);
    // skip fault, relock with err still set, then clear
    cur = (cur + 2) % W;
    hold(oh_of(cur), 3);
    run_clean(7, 3);
    cur = (cur + 1) % W;
    drive1(oh_of(cur), 1'b1);
    hold(oh_of(cur), 2);
    run_clean(4, 3);
    // multi-hot while locked, then the same pattern while searching
    hold(8'h03, 3);
    drive1(8'h03, 1'b1);
    hold(8'h03, 2);
    hold(8'h01, 2);
    hold(8'h03, 3);
    cur = 0;
    hold(8'h01, 3);
    // lock on dwell 5, then a 6-cycle step with err_clr in the fault cycle
    run_clean(7, 5);
    cur = (cur + 1) % W;
    hold(oh_of(cur), 6);
    cur = (cur + 1) % W;
    drive1(oh_of(cur), 1'b0);
    drive1(oh_of(cur), 1'b1);
    hold(oh_of(cur), 3);
    // saturation while locked, then a valid step reporting the saturated dwell
    run_clean(6, 3);
    cur = (cur + 1) % W;
    hold(oh_of(cur), 20);
    run_clean(6, 3);
    // reset while locked
    reset_dut(8'h01);
    cur = 0;
    hold(8'h01, 2);
    run_clean(6, 2);
    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 11);
      if (r < 8) begin
        d = ($urandom_range(0, 5) == 0) ? 4 : 3;
        cur = (cur + 1) % W;
        for (int j = 0; j < d; j++) drive1(oh_of(cur), ($urandom_range(0, 15) == 0));
      end else if (r == 8) begin
        rv = 8'($urandom);
        hold(rv, $urandom_range(1, 3));
        cur = $urandom_range(0, W - 1);
        hold(oh_of(cur), 3);
      end else if (r == 9) begin
        cur = (cur + W - 1) % W;
        hold(oh_of(cur), 3);
      end else if (r == 10) begin
        cur = (cur + 2 + $urandom_range(0, 3)) % W;
        hold(oh_of(cur), 3);
      end else begin
        n = $urandom_range(10, 18);
        hold(oh_of(cur), n);
      end
    end
    hold(oh_of(cur), 2);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
